float_to_angle_fixed: RTL and testbench
=======================================

# float_to_angle_fixed

Pipelined IEEE-754 single-precision to signed fixed-point converter placed directly upstream of the `cosine` CORDIC core. It takes 32-bit float angles from the Nios custom-instruction path and produces the saturated two's-complement fixed-point angle the CORDIC iterations consume. Pipeline handshake: valid/ready with a global stall, plus the `clk_en` convention used by the core.

## Interface
- `WIDTH`, 22: output angle width, signed two's complement.
- `FRAC`, 20: fractional bits of the output (Q(WIDTH-FRAC).FRAC; default Q2.20, range [-2, 2)).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to `clk` externally).
- `clk_en`  in  1  global enable; low freezes all state.
- `in_valid`  in  1  `angle` is valid.
- `in_ready`  out  1  converter accepts `angle` this cycle.
- `angle`  in  32  IEEE-754 single float, radians.
- `out_valid`  out  1  `theta` and flags are valid.
- `out_ready`  in  1  downstream (CORDIC) accepts `theta`.
- `theta`  out  WIDTH  fixed-point angle.
- `sat`  out  1  result saturated (|value| out of range or ±Inf).
- `nan`  out  1  input was NaN; `theta` forced to 0.

## Operation
- Decode: s = angle[31], e = angle[30:23], m = angle[22:0].
- Classify:
  - e=255, m≠0 → NaN.
  - e=255, m=0 → Inf.
  - e=0 → zero/denormal, flushed to 0, no flag.
- Magnitude: M = {1,m} (24 bits); shift sh = e − 150 + FRAC.
  - sh ≥ 0: M << sh.
  - sh < 0: M >> −sh, truncate toward zero.
  - −sh ≥ 24: magnitude 0.
- Saturation (limit L = 2^(WIDTH−1)):
  - Positive with magnitude ≥ L → theta = L−1, sat=1.
  - Negative with magnitude > L → theta = −L, sat=1.
  - Negative with magnitude = L → theta = −L, sat=0 (exact).
  - Inf → saturates by sign, sat=1.
- Sign: theta = s ? −mag : mag; −0 yields 0.
- NaN: theta=0, nan=1, sat=0.
- Shift width: compute in a WIDTH+24-bit intermediate, or detect overflow from sh before shifting. Overflow must never wrap silently.

## Timing
- Latency: 3 cycles from accepted input (in_valid & in_ready) to out_valid, with no stalls.
- Stages:
  - S1: unpack and classify, register.
  - S2: barrel shift, register.
  - S3: saturate, negate, register outputs.
- Stall = ~clk_en | (out_valid & ~out_ready). During stall every stage holds and in_ready=0.
- in_ready = ~stall, so bubbles are not collapsed. Throughput is 1/cycle when unstalled.
- Outputs are stable while out_valid & ~out_ready.
- Reset (async, mid-operation allowed): all valid bits 0, theta=0, sat=0, nan=0, in_ready=0 while reset is low. In-flight data is discarded.
- in_valid low: a bubble (valid=0) advances. Data registers may hold stale values but flags are only meaningful with out_valid.
- clk_en low with out_ready high: no transfer; out_valid holds its value.

## Structure
- Shared package `cordic_pkg`:
  - float field constants: EXP_BIAS=127, MANT_W=23, EXP_MAX=255.
  - typedef for the class enum {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN}.
  - typedef for the stage-1 packed struct.
- One sub-module, `fx_barrel_shift`: bidirectional logarithmic shifter, registered output, honours the stall input. It is natural to isolate and unit-test.
- Top holds the classify stage, saturation/negate stage and valid pipeline.

## Test plan
- 0x3F800000 (1.0) → theta 0x100000, sat=0, nan=0, out_valid exactly 3 cycles after acceptance.
- 0xBF800000 (−1.0) → 0x300000. 0x3F000000 (0.5) → 0x080000. 0x35800000 (2^−20) → 0x000001. 0x35000000 (2^−21) → 0x000000.
- 0x40400000 (3.0) → 0x1FFFFF, sat=1. 0xC0000000 (−2.0) → 0x200000, sat=0. 0xFF800000 (−Inf) → 0x200000, sat=1.
- 0x7FC00000 (NaN) → theta 0, nan=1. 0x00000001 (denormal) and 0x80000000 (−0) → 0, no flags.
- Backpressure: stream 8 values back-to-back, hold out_ready low for 4 cycles mid-stream → in_ready drops the same cycle, theta held stable, no loss or duplication, order preserved. Repeat with clk_en low for 3 cycles.
- Assert reset with 3 values in flight → out_valid=0 and theta=0 immediately. After release, the first new input emerges after 3 cycles with no stale data.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the float-to-angle front end of the cosine CORDIC core.
package cordic_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int EXP_MAX  = 255;
  // Signed shift-amount width; covers e - 150 + FRAC for any 8-bit exponent.
  localparam int SH_W     = 10;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } cls_e;

  // Stage-1 register: classified operand ready for the barrel shift.
  typedef struct packed {
    logic                   valid;
    cls_e                   cls;
    logic                   sign;
    logic [MANT_W:0]        mant;
    logic signed [SH_W-1:0] sh;
  } s1_t;

endpackage

// File: rtl/fx_barrel_shift.sv
// Bidirectional logarithmic shifter with registered, overflow-clamped output.
// Positive i_sh shifts left, negative shifts right (truncating). Any result
// that does not fit in OUT_W bits is clamped to all-ones so it can never wrap.
module fx_barrel_shift #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 23,
  parameter int SH_W  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_stall,
  input  logic [IN_W-1:0]        i_val,
  input  logic signed [SH_W-1:0] i_sh,
  output logic [OUT_W-1:0]       o_mag
);

  localparam int IW = IN_W + OUT_W;
  localparam int NL = $clog2(OUT_W);
  localparam int NR = $clog2(IN_W);

  logic [IW-1:0]    w_v;
  logic [SH_W-1:0]  w_amt;
  logic [OUT_W-1:0] w_res;
  logic [OUT_W-1:0] r_mag;

  // Shift network: log stages in either direction, large shifts short-circuited.
  always_comb begin
    w_v   = '0;
    w_amt = '0;
    w_res = '0;
    if (!i_sh[SH_W-1]) begin
      w_amt = i_sh;
      if (w_amt >= SH_W'(OUT_W)) begin
        w_res = (|i_val) ? '1 : '0;
      end else begin
        w_v = IW'(i_val);
        for (int unsigned k = 0; k < NL; k++) begin
          if (w_amt[k]) w_v = w_v << (1 << k);
        end
        w_res = (|w_v[IW-1:OUT_W]) ? '1 : w_v[OUT_W-1:0];
      end
    end else begin
      w_amt = -i_sh;
      if (w_amt >= SH_W'(IN_W)) begin
        w_res = '0;
      end else begin
        w_v = IW'(i_val);
        for (int unsigned k = 0; k < NR; k++) begin
          if (w_amt[k]) w_v = w_v >> (1 << k);
        end
        w_res = (|w_v[IW-1:OUT_W]) ? '1 : w_v[OUT_W-1:0];
      end
    end
  end

  // Output register, frozen while the pipeline is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mag <= '0;
    end else if (!i_stall) begin
      r_mag <= w_res;
    end
  end

  assign o_mag = r_mag;

endmodule

// File: rtl/float_to_angle_fixed.sv
// IEEE-754 single to saturated signed Q(WIDTH-FRAC).FRAC angle, 3-stage pipeline:
// S1 classify/unpack, S2 barrel shift, S3 saturate/negate.
module float_to_angle_fixed
  import cordic_pkg::*;
#(
  parameter int WIDTH = 22,
  parameter int FRAC  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      angle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] theta,
  output logic             sat,
  output logic             nan
);

  localparam int MW     = WIDTH + 1;
  localparam int SH_OFS = FRAC - EXP_BIAS - MANT_W;
  localparam logic [MW-1:0]    LIM     = MW'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] POS_LIM = WIDTH'(LIM - MW'(1));
  localparam logic [WIDTH-1:0] NEG_LIM = WIDTH'(LIM);

  logic             w_stall;
  logic [7:0]       w_e;
  logic [22:0]      w_m;
  cls_e             w_cls;
  s1_t              w_s1;
  s1_t              r_s1;
  logic             r_s2_valid;
  cls_e             r_s2_cls;
  logic             r_s2_sign;
  logic [MW-1:0]    w_mag;
  logic [WIDTH-1:0] w_theta;
  logic             w_sat;
  logic             w_nan;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_theta;
  logic             r_sat;
  logic             r_nan;

  assign w_stall   = ~clk_en | (r_out_valid & ~out_ready);
  assign in_ready  = reset & ~w_stall;
  assign out_valid = r_out_valid;
  assign theta     = r_theta;
  assign sat       = r_sat;
  assign nan       = r_nan;

  assign w_e = angle[30:23];
  assign w_m = angle[22:0];

  // S1 decode: classify and form the mantissa and signed shift amount.
  always_comb begin
    w_cls = CLS_NORM;
    if (w_e == 8'(EXP_MAX)) begin
      w_cls = (|w_m) ? CLS_NAN : CLS_INF;
    end else if (w_e == '0) begin
      w_cls = CLS_ZERO;
    end
    w_s1.valid = in_valid;
    w_s1.cls   = w_cls;
    w_s1.sign  = angle[31];
    // Non-normal classes feed a zero mantissa so the shifter yields 0 for them.
    w_s1.mant  = (w_cls == CLS_NORM) ? {1'b1, w_m} : '0;
    w_s1.sh    = signed'(SH_W'(w_e)) + signed'(SH_W'(SH_OFS));
  end

  // S1 register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= '0;
    end else if (!w_stall) begin
      r_s1 <= w_s1;
    end
  end

  fx_barrel_shift #(
    .IN_W  (MANT_W + 1),
    .OUT_W (MW),
    .SH_W  (SH_W)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .i_stall (w_stall),
    .i_val   (r_s1.mant),
    .i_sh    (r_s1.sh),
    .o_mag   (w_mag)
  );

  // S2 sideband registers travelling alongside the shifter output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_s2_cls   <= CLS_ZERO;
      r_s2_sign  <= 1'b0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1.valid;
      r_s2_cls   <= r_s1.cls;
      r_s2_sign  <= r_s1.sign;
    end
  end

  // S3 saturate and negate; -L is exactly representable, so it is not flagged.
  always_comb begin
    w_theta = '0;
    w_sat   = 1'b0;
    w_nan   = 1'b0;
    case (r_s2_cls)
      CLS_NAN: w_nan = 1'b1;
      CLS_INF: begin
        w_sat   = 1'b1;
        w_theta = r_s2_sign ? NEG_LIM : POS_LIM;
      end
      default: begin
        if (!r_s2_sign) begin
          if (w_mag >= LIM) begin
            w_sat   = 1'b1;
            w_theta = POS_LIM;
          end else begin
            w_theta = w_mag[WIDTH-1:0];
          end
        end else begin
          if (w_mag > LIM) begin
            w_sat   = 1'b1;
            w_theta = NEG_LIM;
          end else if (w_mag == LIM) begin
            w_theta = NEG_LIM;
          end else begin
            w_theta = -w_mag[WIDTH-1:0];
          end
        end
      end
    endcase
  end

  // S3 output registers, held while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_theta     <= '0;
      r_sat       <= 1'b0;
      r_nan       <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_s2_valid;
      r_theta     <= w_theta;
      r_sat       <= w_sat;
      r_nan       <= w_nan;
    end
  end

endmodule

// File: tb/tb_float_to_angle_fixed.sv
// Directed, table-driven bench for float_to_angle_fixed (default Q2.20).
module tb_float_to_angle_fixed;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] angle;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] theta;
  logic        sat;
  logic        nan;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [21:0] th;
    logic        sat;
    logic        nan;
  } vec_t;

  localparam int NV = 21;
  vec_t tv[NV];

  float_to_angle_fixed #(
    .WIDTH (22),
    .FRAC  (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle     (angle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .theta     (theta),
    .sat       (sat),
    .nan       (nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Single transaction from an unstalled pipe: exact 3-cycle latency, then drain.
  task automatic run_one(input int idx);
    angle     = tv[idx].a;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    clk_en    = 1'b1;
    #1;
    chk($sformatf("in_ready[%0d]", idx), 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    angle    = '0;
    chk($sformatf("lat1[%0d]", idx), 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("lat2[%0d]", idx), 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("lat3[%0d]", idx), 32'(out_valid), 32'd1);
    chk($sformatf("theta[%0d]", idx), 32'(theta), 32'(tv[idx].th));
    chk($sformatf("sat[%0d]", idx), 32'(sat), 32'(tv[idx].sat));
    chk($sformatf("nan[%0d]", idx), 32'(nan), 32'(tv[idx].nan));
    @(posedge clk); #1;
    chk($sformatf("drain[%0d]", idx), 32'(out_valid), 32'd0);
  endtask

  // Stream vectors 0..7 back-to-back with a stall window of out_ready or clk_en.
  task automatic run_stream(input bit use_clken);
    int          sent;
    int          got;
    logic        prev_hold;
    logic [21:0] prev_th;
    logic        exp_stall;
    sent      = 0;
    got       = 0;
    prev_hold = 1'b0;
    prev_th   = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      in_valid = (sent < 8);
      angle    = (sent < 8) ? tv[sent].a : 32'h0;
      if (use_clken) begin
        out_ready = 1'b1;
        clk_en    = !(c >= 4 && c < 7);
      end else begin
        clk_en    = 1'b1;
        out_ready = !(c >= 4 && c < 8);
      end
      #1;
      exp_stall = !clk_en || (out_valid && !out_ready);
      chk($sformatf("stream_in_ready c%0d", c), 32'(in_ready), 32'(!exp_stall));
      if (prev_hold) chk($sformatf("stream_hold c%0d", c), 32'(theta), 32'(prev_th));
      if (out_valid && out_ready && clk_en) begin
        chk($sformatf("stream_theta[%0d]", got), 32'(theta), 32'(tv[got].th));
        chk($sformatf("stream_sat[%0d]", got), 32'(sat), 32'(tv[got].sat));
        chk($sformatf("stream_nan[%0d]", got), 32'(nan), 32'(tv[got].nan));
        got++;
      end
      prev_hold = exp_stall && out_valid;
      prev_th   = theta;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clk_en    = 1'b1;
    chk("stream_sent", 32'(sent), 32'd8);
    chk("stream_got", 32'(got), 32'd8);
    @(posedge clk); #1;
    chk("stream_no_extra", 32'(out_valid), 32'd0);
  endtask

  initial begin
    tv[0]  = '{32'h3F800000, 22'h100000, 1'b0, 1'b0}; // 1.0
    tv[1]  = '{32'hBF800000, 22'h300000, 1'b0, 1'b0}; // -1.0
    tv[2]  = '{32'h3F000000, 22'h080000, 1'b0, 1'b0}; // 0.5
    tv[3]  = '{32'h35800000, 22'h000001, 1'b0, 1'b0}; // 2^-20
    tv[4]  = '{32'h35000000, 22'h000000, 1'b0, 1'b0}; // 2^-21
    tv[5]  = '{32'h40400000, 22'h1FFFFF, 1'b1, 1'b0}; // 3.0
    tv[6]  = '{32'hC0000000, 22'h200000, 1'b0, 1'b0}; // -2.0 exact
    tv[7]  = '{32'hFF800000, 22'h200000, 1'b1, 1'b0}; // -Inf
    tv[8]  = '{32'h7FC00000, 22'h000000, 1'b0, 1'b1}; // NaN
    tv[9]  = '{32'h00000001, 22'h000000, 1'b0, 1'b0}; // denormal
    tv[10] = '{32'h80000000, 22'h000000, 1'b0, 1'b0}; // -0
    tv[11] = '{32'h3FFFFFFF, 22'h1FFFFF, 1'b0, 1'b0}; // just under 2.0
    tv[12] = '{32'hBFFFFFFF, 22'h200001, 1'b0, 1'b0}; // just above -2.0
    tv[13] = '{32'h40000000, 22'h1FFFFF, 1'b1, 1'b0}; // 2.0
    tv[14] = '{32'h7F7FFFFF, 22'h1FFFFF, 1'b1, 1'b0}; // max finite
    tv[15] = '{32'hC0000001, 22'h200000, 1'b0, 1'b0}; // truncates to exactly -L
    tv[16] = '{32'hC0000004, 22'h200000, 1'b1, 1'b0}; // beyond -L
    tv[17] = '{32'h7F800000, 22'h1FFFFF, 1'b1, 1'b0}; // +Inf
    tv[18] = '{32'h3E000000, 22'h020000, 1'b0, 1'b0}; // 0.125
    tv[19] = '{32'hC0A00000, 22'h200000, 1'b1, 1'b0}; // -5.0
    tv[20] = '{32'h80000001, 22'h000000, 1'b0, 1'b0}; // negative denormal

    reset     = 1'b0;
    clk_en    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    angle     = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_theta", 32'(theta), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_nan", 32'(nan), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_one(i);

    run_stream(1'b0);
    run_stream(1'b1);

    // Reset with three values in flight, then a fresh value through a clean pipe.
    out_ready = 1'b1;
    clk_en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      angle    = tv[5 + i].a;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("inflight_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_theta", 32'(theta), 32'd0);
    chk("midrst_sat", 32'(sat), 32'd0);
    chk("midrst_nan", 32'(nan), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("postrst_idle c%0d", i), 32'(out_valid), 32'd0);
    end
    run_one(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
